// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the fetch/data port arbiter: one outstanding request,
// completed by a single-cycle acknowledge.
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus.
// Data wins ties; each transaction ends with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [1:0]         d_size,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic [31:0]        d_rdata,
  output logic               d_ready,
  mem_port_arbiter_if.master mem,
  output logic               stall,
  output logic               bus_err,
  output logic [1:0]         err_code
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_WAIT = 2'd1;
  localparam logic [1:0] D_WAIT  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int unsigned   CntW     = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
  localparam logic [31:0]   AddrMask = 32'hFFFF_FFFC;

  logic [1:0]      state, state_next;
  logic            armed;
  logic [CntW-1:0] cnt, cnt_inc;
  logic            hw, hi_half;
  logic            d_hw, d_misaligned;
  logic [3:0]      d_be;
  logic [31:0]     d_wdata_fmt, rdata_fmt;
  logic            in_wait, grant_d, grant_if, ack, timeout;

  always_comb begin
    d_hw         = (d_size == 2'b01);
    d_misaligned = d_hw ? d_addr[0] : (d_addr[1:0] != 2'b00);
    d_be         = !d_hw ? 4'b1111 : (d_addr[1] ? 4'b1100 : 4'b0011);
    d_wdata_fmt  = d_hw ? {2{d_wdata[15:0]}} : d_wdata;
    if (!hw) begin
      rdata_fmt = mem.mem_rdata;
    end else if (hi_half) begin
      rdata_fmt = {{16{mem.mem_rdata[31]}}, mem.mem_rdata[31:16]};
    end else begin
      rdata_fmt = {{16{mem.mem_rdata[15]}}, mem.mem_rdata[15:0]};
    end
    cnt_inc  = cnt + 1'b1;
    in_wait  = (state == IF_WAIT) || (state == D_WAIT);
    // armed blocks a grant on the first edge after reset release
    grant_d  = (state == IDLE) && armed && d_req;
    grant_if = (state == IDLE) && armed && !d_req && if_req;
    ack      = in_wait && mem.mem_ack;
    timeout  = in_wait && !mem.mem_ack && (cnt_inc == CntMax);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = d_misaligned ? DONE : D_WAIT;
        end else if (grant_if) begin
          state_next = IF_WAIT;
        end
      end
      IF_WAIT, D_WAIT: begin
        if (ack || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      armed         <= 1'b0;
      cnt           <= '0;
      hw            <= 1'b0;
      hi_half       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      if_ready      <= 1'b0;
      d_ready       <= 1'b0;
      bus_err       <= 1'b0;
      err_code      <= 2'b00;
      stall         <= 1'b0;
    end else begin
      state    <= state_next;
      armed    <= 1'b1;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
      stall    <= (if_req | d_req) && (state_next != DONE);
      if (grant_d) begin
        cnt     <= '0;
        hw      <= d_hw;
        hi_half <= d_addr[1];
        if (d_misaligned) begin
          err_code <= 2'b01;
          bus_err  <= 1'b1;
          d_rdata  <= '0;
          d_ready  <= 1'b1;
        end else begin
          err_code      <= 2'b00;
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= d_we;
          mem.mem_addr  <= d_addr & AddrMask;
          mem.mem_be    <= d_be;
          mem.mem_wdata <= d_wdata_fmt;
        end
      end else if (grant_if) begin
        cnt          <= '0;
        err_code     <= 2'b00;
        mem.mem_req  <= 1'b1;
        mem.mem_we   <= 1'b0;
        mem.mem_addr <= if_addr & AddrMask;
        mem.mem_be   <= 4'b1111;
      end else if (ack) begin
        mem.mem_req <= 1'b0;
        if (state == D_WAIT) begin
          d_rdata <= rdata_fmt;
          d_ready <= 1'b1;
        end else begin
          if_rdata <= mem.mem_rdata;
          if_ready <= 1'b1;
        end
      end else if (timeout) begin
        mem.mem_req <= 1'b0;
        err_code    <= 2'b10;
        bus_err     <= 1'b1;
        if (state == D_WAIT) begin
          d_rdata <= '0;
          d_ready <= 1'b1;
        end else begin
          if_rdata <= '0;
          if_ready <= 1'b1;
        end
      end else if (in_wait) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised transaction-level bench for mem_port_arbiter; expected results are
// derived per transaction from the port rules, acting as the memory itself.
module tb_mem_port_arbiter;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] if_rdata, d_rdata;
  logic        if_ready, d_ready, stall, bus_err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter_if mem_bus ();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_size   (d_size),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem      (mem_bus),
    .stall    (stall),
    .bus_err  (bus_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return 32'($signed(h));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_bus.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_bus.mem_we), 32'd0);
    check({tag, "_mem_be"}, 32'(mem_bus.mem_be), 32'd0);
    check({tag, "_mem_addr"}, mem_bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_bus.mem_wdata, 32'd0);
    check({tag, "_readies"}, 32'({if_ready, d_ready}), 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_err"}, 32'({bus_err, err_code}), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // Starts at a negedge with the arbiter idle; returns at the negedge of the
  // idle cycle that follows the completion pulse. lat = request cycles before ack.
  task automatic run_txn(input bit is_d, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input bit both);
    bit          hw, mis, ok, done;
    int          high, exp_high;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, exp_addr;
    logic [1:0]  exp_err;

    hw       = is_d && (size == 2'b01);
    mis      = is_d && (hw ? addr[0] : (addr[1:0] != 2'b00));
    ok       = !mis && (lat + 1 <= int'(TIMEOUT));
    exp_high = mis ? 0 : (ok ? lat + 1 : int'(TIMEOUT));
    exp_addr = {addr[31:2], 2'b00};
    exp_be   = hw ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    exp_wd   = hw ? {wdata[15:0], wdata[15:0]} : wdata;
    if (!ok) exp_rd = 32'd0;
    else if (!hw) exp_rd = rdata;
    else if (addr[1]) exp_rd = sext16(rdata[31:16]);
    else exp_rd = sext16(rdata[15:0]);
    exp_err = mis ? 2'b01 : (ok ? 2'b00 : 2'b10);

    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = rdata;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
      if (both) begin
        if_req = 1'b1; if_addr = $urandom;
      end
    end else begin
      if_req = 1'b1; if_addr = addr;
      d_we = 1'($urandom); d_size = 2'($urandom); d_addr = $urandom; d_wdata = $urandom;
    end

    @(negedge clk);
    check("grant_stall", 32'(stall), 32'(!mis));
    if (!mis) begin
      check("grant_mem_req", 32'(mem_bus.mem_req), 32'd1);
      check("grant_mem_addr", mem_bus.mem_addr, exp_addr);
      check("grant_mem_be", 32'(mem_bus.mem_be), 32'(exp_be));
      check("grant_mem_we", 32'(mem_bus.mem_we), 32'(is_d && we));
      if (is_d && we) check("grant_mem_wdata", mem_bus.mem_wdata, exp_wd);
      check("grant_err_clr", 32'(err_code), 32'd0);
    end
    if (!both && $urandom_range(0, 1) == 1) begin
      d_req = 1'b0; if_req = 1'b0;
    end

    high = 0;
    done = 1'b0;
    for (int c = 0; c < int'(TIMEOUT) + 8 && !done; c++) begin
      if (if_ready || d_ready) begin
        done = 1'b1;
      end else begin
        if (mem_bus.mem_req) high++;
        mem_bus.mem_ack = (high == lat + 1);
        @(negedge clk);
      end
    end

    check("done_seen", 32'(done), 32'd1);
    check("ready_port", 32'({if_ready, d_ready}), is_d ? 32'd1 : 32'd2);
    check("rdata", is_d ? d_rdata : if_rdata, exp_rd);
    check("bus_err", 32'(bus_err), 32'(exp_err != 2'b00));
    check("err_code", 32'(err_code), 32'(exp_err));
    check("req_cycles", 32'(high), 32'(exp_high));
    check("done_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("done_stall", 32'(stall), 32'd0);

    d_req = 1'b0;
    if (!both) if_req = 1'b0;
    mem_bus.mem_ack = 1'($urandom);  // stray ack outside a wait state
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check("idle_quiet", 32'({if_ready, d_ready, bus_err, mem_bus.mem_req}), 32'd0);
    check("idle_err_hold", 32'(err_code), 32'(exp_err));
    check("idle_stall", 32'(stall), 32'(both));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          is_d, we, both;
    logic [1:0]  size;
    logic [31:0] addr;
    int          r, lat;

    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0;
    d_addr = '0; d_wdata = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Simultaneous requests: data first, fetch after one idle cycle
    run_txn(1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1, 1'b1);
    run_txn(1'b0, 1'b0, 2'b00, 32'h0000_4006, 32'd0, 32'h1357_9BDF, 2, 1'b0);
    // Halfword reads and write
    run_txn(1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'd0, 32'h8001_1234, 0, 1'b0);
    run_txn(1'b1, 1'b0, 2'b01, 32'h0000_0200, 32'd0, 32'h8001_1234, 0, 1'b0);
    run_txn(1'b1, 1'b1, 2'b01, 32'h0000_0206, 32'h0000_ABCD, 32'd0, 3, 1'b0);
    // Misaligned word and halfword
    run_txn(1'b1, 1'b0, 2'b00, 32'h0000_0101, 32'd0, 32'h1111_1111, 0, 1'b0);
    run_txn(1'b1, 1'b1, 2'b01, 32'h0000_0103, 32'h55AA_55AA, 32'd0, 0, 1'b0);
    // Fetch timeout, then ack landing on the last allowed cycle
    run_txn(1'b0, 1'b0, 2'b00, 32'h0000_0300, 32'd0, 32'hCAFE_F00D, 100, 1'b0);
    run_txn(1'b0, 1'b0, 2'b00, 32'h0000_0300, 32'd0, 32'hCAFE_F00D, 14, 1'b0);

    for (int i = 0; i < 60; i++) begin
      is_d = 1'($urandom);
      we   = 1'($urandom);
      size = 2'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) addr[1] = 1'b0;
      r = int'($urandom_range(0, 9));
      if (r <= 5) lat = int'($urandom_range(0, 4));
      else if (r == 6) lat = 13 + int'($urandom_range(0, 2));
      else if (r == 7) lat = 50;
      else lat = int'($urandom_range(5, 12));
      both = is_d && ($urandom_range(0, 3) == 0);
      run_txn(is_d, we, size, addr, $urandom, $urandom, lat, both);
      if (both) run_txn(1'b0, 1'b0, 2'b00, $urandom, 32'd0, $urandom, 1, 1'b0);
    end

    // Reset while a data read waits for its ack
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0000_0400;
    mem_bus.mem_rdata = 32'h2468_ACE0;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    check("rst_pre_mem_req", 32'(mem_bus.mem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    check("rst_no_ready", 32'({if_ready, d_ready}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_early_grant", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    check("rst_second_edge_grant", 32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    check("rst_after_ready", 32'(d_ready), 32'd1);
    check("rst_after_rdata", d_rdata, 32'h2468_ACE0);
    d_req = 1'b0;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 2'b00, 32'h0000_0808, 32'd0, 32'h0F0F_0F0F, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
